// File: rtl/mult_rr_sequencer_pkg.sv
// Shared types and helpers for the two-requester multiplier sequencer.
package mult_seq_pkg;

  // Sequencer phases: wait for a request, grant, iterate, publish the product.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width of the iteration counter; it only has to reach N-1.
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mult_rr_sequencer_if.sv
// Requester-facing bundle: level requests, operands, grant and result.
interface mult_rr_sequencer_if #(
  parameter int N = 4
);
  logic [1:0]     req;
  logic [N-1:0]   a0;
  logic [N-1:0]   b0;
  logic [N-1:0]   a1;
  logic [N-1:0]   b1;
  logic [1:0]     gnt;
  logic           busy;
  logic           done;
  logic           done_id;
  logic [2*N-1:0] product;

  // Requester side.
  modport master (
    output req, a0, b0, a1, b1,
    input  gnt, busy, done, done_id, product
  );

  // Sequencer side.
  modport slave (
    input  req, a0, b0, a1, b1,
    output gnt, busy, done, done_id, product
  );
endinterface

// File: rtl/mult_rr_sequencer_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes
// to the requester that did not win last time.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win,
  output logic       win_id
);

  // Pick the winner and its one-hot form.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    win_id = 1'b0;
    win    = 2'b00;
    case (req)
      2'b01:   win_id = 1'b0;
      2'b10:   win_id = 1'b1;
      2'b11:   win_id = ~last;
      default: win_id = 1'b0;
    endcase
    if (req != 2'b00) win = win_id ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mult_rr_sequencer.sv
// Shares one iterative shift-and-add N x N multiplier between two requesters.
// Round-robin picks a winner in IDLE, LOAD pulses its grant, RUN does one
// add/shift per cycle for N cycles, DONE presents the 2N-bit product.
module mult_rr_sequencer
  import mult_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_rr_sequencer_if.slave  bus
);

  localparam int CW = cnt_w(N);

  state_t           state_q;
  state_t           state_d;
  logic [N-1:0]     mcand_q;
  logic [N-1:0]     mplier_q;
  logic [2*N-1:0]   acc_q;
  logic [CW-1:0]    cnt_q;
  logic             id_q;
  logic             last_q;
  logic [1:0]       gnt_q;
  logic             done_q;
  logic             done_id_q;
  logic [2*N-1:0]   product_q;

  logic [1:0]       win;
  logic             win_id;
  logic             capture;
  logic             last_iter;
  logic [N:0]       sum;
  logic [2*N-1:0]   acc_next;
  logic [N-1:0]     a_sel;
  logic [N-1:0]     b_sel;

  rr_arb2 u_arb (
    .req    (bus.req),
    .last   (last_q),
    .win    (win),
    .win_id (win_id)
  );

  // Next-state decode plus the capture / final-iteration strobes.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    last_iter = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          capture = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (cnt_q == CW'(N - 1)) begin
          last_iter = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One shift-and-add step: add into the upper half with carry, then shift right.
  always_comb begin
    sum      = {1'b0, acc_q[2*N-1:N]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_next = {sum, acc_q[N-1:1]};
    a_sel    = win_id ? bus.a1 : bus.a0;
    b_sel    = win_id ? bus.b1 : bus.b0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    else        state_q <= state_d;
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      gnt_q     <= 2'b00;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      product_q <= '0;
    end else begin
      gnt_q  <= capture ? win : 2'b00;
      done_q <= last_iter;
      if (capture) begin
        mcand_q  <= a_sel;
        mplier_q <= b_sel;
        acc_q    <= '0;
        cnt_q    <= '0;
        id_q     <= win_id;
        last_q   <= win_id;
      end
      if (state_q == RUN) begin
        acc_q    <= acc_next;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
      end
      if (last_iter) begin
        product_q <= acc_next;
        done_id_q <= id_q;
      end
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.product = product_q;

endmodule
